// File: rtl/ro_enc_multi.sv
// ro_enc_multi: multi-channel rotary encoder front end.
// Each channel synchronises its A/B pins, debounces the 2-bit level, decodes
// quadrature steps into a signed saturating accumulator, and raises a
// maskable pending flag. Illegal (both-bits-changed) transitions set a
// sticky error flag.
// Build option: define RO_ENC_DETENT_EN for x2 detent mode, where only legal
// steps ending in 00 or 11 are counted. Default build is x4 mode.
module ro_enc_multi #(
   parameter int CH_NUM   = 4,
   parameter int CNT_W    = 8,
   parameter int DEB_LEN  = 4,
   parameter int SYNC_STG = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [CH_NUM-1:0]         i_ro_enc_state_a,
   input  logic [CH_NUM-1:0]         i_ro_enc_state_b,
   input  logic [CH_NUM-1:0]         i_sw_intr_clear,
   input  logic [CH_NUM-1:0]         i_irq_mask,
   output logic                      o_ro_enc_irq,
   output logic [CH_NUM-1:0]         o_ro_enc_pend,
   output logic [CH_NUM-1:0]         o_ro_enc_dir,
   output logic [CH_NUM-1:0]         o_ro_enc_err,
   output logic [CH_NUM*CNT_W-1:0]   o_ro_enc_data
);

   localparam logic [CNT_W-1:0] MAX_V = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] MIN_V = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [7:0]       DEB_V = 8'(DEB_LEN);

   // Position of a Gray-coded {A,B} level along the CW sequence 00,01,11,10.
   function automatic logic [1:0] gpos(input logic [1:0] g);
      gpos = {g[1], g[1] ^ g[0]};
   endfunction

   for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
      logic [SYNC_STG-1:0] sync_a_q, sync_b_q;
      logic [1:0]          s;
      logic [1:0]          s_prev_q;
      logic [1:0]          filt_q, filt_d;
      logic [7:0]          cnt_q, cnt_d;
      logic                primed_q, primed_d;
      logic                upd;
      logic [1:0]          diff;
      logic                count_ok;
      logic                step_cw, step_ccw, illegal;
      logic                clr;
      logic [CNT_W-1:0]    base;
      logic [CNT_W-1:0]    data_q, data_d;
      logic                pend_q, pend_d;
      logic                dir_q, dir_d;
      logic                err_q, err_d;

      assign s   = {sync_a_q[SYNC_STG-1], sync_b_q[SYNC_STG-1]};
      assign clr = i_sw_intr_clear[n];

      // Pin synchronisers; the last stage is the level seen by the filter.
      always_ff @(posedge i_clk) begin
         if (!i_rst) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
         end else begin
            sync_a_q <= {sync_a_q[SYNC_STG-2:0], i_ro_enc_state_a[n]};
            sync_b_q <= {sync_b_q[SYNC_STG-2:0], i_ro_enc_state_b[n]};
         end
      end

      // Debounce: accept S into F once it has been stable for DEB_LEN
      // counted cycles. Before priming, F is loaded without decoding.
      always_comb begin
         cnt_d    = cnt_q;
         filt_d   = filt_q;
         primed_d = primed_q;
         upd      = 1'b0;
         if (s != s_prev_q) begin
            cnt_d = '0;
         end else if (!primed_q) begin
            if (cnt_q == DEB_V) begin
               filt_d   = s;
               primed_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end else if (s == filt_q) begin
            cnt_d = '0;
         end else if (cnt_q == DEB_V) begin
            filt_d = s;
            cnt_d  = '0;
            upd    = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      // Step decode from old filtered level to newly accepted level.
      always_comb begin
         diff = gpos(s) - gpos(filt_q);
`ifdef RO_ENC_DETENT_EN
         count_ok = (s == 2'b00) || (s == 2'b11);
`else
         count_ok = 1'b1;
`endif
         step_cw  = upd && (diff == 2'd1) && count_ok;
         step_ccw = upd && (diff == 2'd3) && count_ok;
         illegal  = upd && (diff == 2'd2);
      end

      // Accumulator, pending, direction and error; a step on the clear
      // edge is applied on top of the cleared state.
      always_comb begin
         base   = clr ? '0 : data_q;
         data_d = base;
         pend_d = clr ? 1'b0 : pend_q;
         dir_d  = clr ? 1'b0 : dir_q;
         err_d  = clr ? 1'b0 : (err_q | illegal);
         if (step_cw) begin
            pend_d = 1'b1;
            dir_d  = 1'b0;
            if (base != MAX_V) data_d = base + CNT_W'(1);
         end else if (step_ccw) begin
            pend_d = 1'b1;
            dir_d  = 1'b1;
            if (base != MIN_V) data_d = base - CNT_W'(1);
         end
      end

      // Channel state registers.
      always_ff @(posedge i_clk) begin
         if (!i_rst) begin
            s_prev_q <= '0;
            filt_q   <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            s_prev_q <= s;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
         end
      end

      assign o_ro_enc_data[n*CNT_W +: CNT_W] = data_q;
      assign o_ro_enc_pend[n]                = pend_q;
      assign o_ro_enc_dir[n]                 = dir_q;
      assign o_ro_enc_err[n]                 = err_q;
   end

   assign o_ro_enc_irq = |(o_ro_enc_pend & ~i_irq_mask);

endmodule
